// File: rtl/telem_storage_n.sv
// telem_storage_n: NCH-channel discrete telemetry storage.
// The qualified slot bit is edge-detected, passed through a retriggerable
// counter delay, and loads the target channel's staged register (dcr).
// When a channel's slot comes round, dcr is copied into ddcr.
// Every change of ddcr is reported through a small first-word-fall-through
// event FIFO. A sticky flag records any event that had to be dropped.
module telem_storage_n #(
  parameter int NCH   = 4,
  parameter int DLY   = 80,
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(NCH)
) (
  input  logic           SIM_CLK,
  input  logic           SIM_RST,
  input  logic [NCH-1:0] phase,
  input  logic [NCH-1:0] dcs,
  input  logic           din,
  input  logic           zerw,
  input  logic           bon,
  output logic [NCH-1:0] dcr,
  output logic [NCH-1:0] ddcr,
  output logic           dlo,
  output logic           busy,
  output logic           ev_valid,
  output logic [IW:0]    ev_data,
  input  logic           ev_ready,
  output logic           ev_ovf,
  input  logic           clr_ovf
);

  localparam int CW = $clog2(DLY + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [IW-1:0]  act_ch;
  logic [IW-1:0]  chan_q;
  logic [IW-1:0]  target;
  logic [IW-1:0]  chg_idx;
  logic           ddip;
  logic           ddip_q;
  logic           ddip_prev;
  logic           start;
  logic           dlo_set;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] chg;
  logic           chg_any;
  logic           chg_multi;
  logic [IW:0]    mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    fcnt;
  logic           pop;
  logic           push_ok;
  logic           drop;

  // Active channel: lowest set phase bit, and its qualified data bit.
  always_comb begin
    act_ch = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (phase[NCH-1-i]) act_ch = IW'(NCH-1-i);
    end
    ddip = dcs[act_ch] ? (din & zerw) : ddcr[act_ch];
  end

  // Delay start/expiry. A restart on the terminal count suppresses the pulse.
  always_comb begin
    start   = ddip_q & ~ddip_prev & bon;
    dlo_set = bon & ~start & (cnt == CW'(1));
  end

  // Channels whose ddcr will change this edge; the lowest one is reported.
  always_comb begin
    chg       = phase & (dcr ^ ddcr);
    chg_any   = |chg;
    chg_multi = |(chg & (chg - NCH'(1)));
    chg_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (chg[NCH-1-i]) chg_idx = IW'(NCH-1-i);
    end
  end

  // FIFO handshake: a pop on a full FIFO frees the slot for a concurrent push.
  always_comb begin
    pop     = ev_valid & ev_ready;
    push_ok = chg_any & ((fcnt != FULL) | pop);
    drop    = chg_multi | (chg_any & ~push_ok);
  end

  assign busy     = (cnt != '0);
  assign ev_valid = (fcnt != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

  // Edge detector, retriggerable delay counter and expiry pulse.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      ddip_q    <= 1'b0;
      ddip_prev <= 1'b0;
      chan_q    <= '0;
      target    <= '0;
      cnt       <= '0;
      dlo       <= 1'b0;
    end else begin
      ddip_prev <= ddip_q;
      if (|phase) begin
        ddip_q <= ddip;
        chan_q <= act_ch;
      end
      dlo <= dlo_set;
      if (!bon) begin
        cnt <= '0;
      end else if (start) begin
        cnt    <= CW'(DLY);
        target <= chan_q;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Channel registers: slot copies dcr into ddcr and clears dcr; expiry set wins.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      dcr  <= '0;
      ddcr <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (phase[i]) begin
          ddcr[i] <= dcr[i];
          dcr[i]  <= 1'b0;
        end
        if (dlo_set && (target == IW'(i))) dcr[i] <= 1'b1;
      end
    end
  end

  // Event FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      ev_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fcnt <= fcnt + (PW+1)'(1);
        2'b01:   fcnt <= fcnt - (PW+1)'(1);
        default: fcnt <= fcnt;
      endcase
      if (drop)         ev_ovf <= 1'b1;
      else if (clr_ovf) ev_ovf <= 1'b0;
    end
  end

  // Event storage; contents are only visible through ev_data while valid.
  always_ff @(posedge SIM_CLK) begin
    if (push_ok) mem[wr_ptr] <= {chg_idx, dcr[chg_idx]};
  end

endmodule

// File: tb/tb_telem_storage_n.sv
// Testbench for telem_storage_n: directed scenarios plus randomized traffic,
// checked against an event-level reference model and an event scoreboard.
module tb_telem_storage_n;

  localparam int NCH   = 4;
  localparam int DLY   = 4;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic           SIM_CLK = 1'b0;
  logic           SIM_RST;
  logic [NCH-1:0] phase, dcs;
  logic           din, zerw, bon, ev_ready, clr_ovf;
  logic [NCH-1:0] dcr, ddcr;
  logic           dlo, busy, ev_valid, ev_ovf;
  logic [IW:0]    ev_data;

  always #5 SIM_CLK = ~SIM_CLK;

  telem_storage_n #(.NCH(NCH), .DLY(DLY), .DEPTH(DEPTH)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .phase(phase), .dcs(dcs),
    .din(din), .zerw(zerw), .bon(bon), .dcr(dcr), .ddcr(ddcr), .dlo(dlo),
    .busy(busy), .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
    .ev_ovf(ev_ovf), .clr_ovf(clr_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: channel bits as int arrays, the delay as an absolute
  // expiry edge number, the FIFO as a queue.
  int m_dcr[NCH];
  int m_ddcr[NCH];
  int m_ddip_q, m_ddip_prev, m_chan;
  int m_armed, m_fire_at, m_target;
  int m_dlo, m_ovf, m_edge;
  int mq[$];
  int exp_q[$];

  function automatic logic [31:0] pack(input int a[NCH]);
    logic [31:0] r = '0;
    for (int i = 0; i < NCH; i++) r[i] = (a[i] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_dcr[i]  = 0;
      m_ddcr[i] = 0;
    end
    m_ddip_q = 0; m_ddip_prev = 0; m_chan = 0;
    m_armed = 0; m_fire_at = 0; m_target = 0;
    m_dlo = 0; m_ovf = 0; m_edge = 0;
    mq.delete();
  endtask

  // Advance the model across the coming clock edge using the applied inputs.
  task automatic model_step();
    int a, ddip, start, fire, drop, e;
    int nd[NCH];
    int ndd[NCH];
    int changed[$];
    a = -1;
    for (int i = 0; i < NCH; i++) if (phase[i] && a < 0) a = i;
    ddip = 0;
    if (a >= 0) ddip = dcs[a] ? int'(din & zerw) : m_ddcr[a];
    start = (m_ddip_q == 1 && m_ddip_prev == 0 && bon) ? 1 : 0;
    fire  = (bon && !start && m_armed && m_fire_at == m_edge) ? 1 : 0;
    for (int i = 0; i < NCH; i++) begin
      nd[i]  = phase[i] ? 0 : m_dcr[i];
      if (fire && m_target == i) nd[i] = 1;
      ndd[i] = phase[i] ? m_dcr[i] : m_ddcr[i];
      if (ndd[i] != m_ddcr[i]) changed.push_back(i);
    end
    drop = (changed.size() > 1) ? 1 : 0;
    if (mq.size() > 0 && ev_ready) void'(mq.pop_front());
    if (changed.size() > 0) begin
      e = changed[0] * 2 + ndd[changed[0]];
      if (mq.size() < DEPTH) begin
        mq.push_back(e);
        exp_q.push_back(e);
      end else begin
        drop = 1;
      end
    end
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    if (!bon) m_armed = 0;
    else if (start) begin
      m_armed = 1; m_fire_at = m_edge + DLY; m_target = m_chan;
    end else if (fire) m_armed = 0;
    m_ddip_prev = m_ddip_q;
    if (a >= 0) begin
      m_ddip_q = ddip; m_chan = a;
    end
    m_dlo = fire;
    m_dcr = nd;
    m_ddcr = ndd;
    m_edge++;
  endtask

  // State monitor: compare registered outputs with the model after each edge.
  always @(posedge SIM_CLK) begin
    #1;
    if (chk_en) begin
      chk("dcr", dcr, pack(m_dcr));
      chk("ddcr", ddcr, pack(m_ddcr));
      chk("dlo", dlo, m_dlo);
      chk("busy", busy, m_armed);
      chk("ev_valid", ev_valid, (mq.size() > 0) ? 1 : 0);
      chk("ev_ovf", ev_ovf, m_ovf);
    end
  end

  // Event monitor: every DUT pop must match the oldest expected event.
  always @(negedge SIM_CLK) begin
    if (chk_en && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ev_pop: got entry %0d, expected no entry (t=%0t)", ev_data, $time);
      end else begin
        chk("ev_data", ev_data, exp_q.pop_front());
      end
    end
  end

  task automatic apply(input logic [NCH-1:0] ph, input logic [NCH-1:0] cs,
                       input logic d, input logic z, input logic b,
                       input logic r, input logic c);
    phase = ph; dcs = cs; din = d; zerw = z; bon = b; ev_ready = r; clr_ovf = c;
    model_step();
    @(posedge SIM_CLK);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dcr"}, dcr, 0);
    chk({tag, "_ddcr"}, ddcr, 0);
    chk({tag, "_dlo"}, dlo, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ev_valid"}, ev_valid, 0);
    chk({tag, "_ev_data"}, ev_data, 0);
    chk({tag, "_ev_ovf"}, ev_ovf, 0);
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge.
  task automatic mid_reset();
    #1 SIM_RST = 1'b1;
    #1 check_all_zero("midrst");
    model_reset();
    exp_q.delete();
    @(posedge SIM_CLK);
    #2 SIM_RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int rdy_pct;
    int sel;
    logic [NCH-1:0] ph;
    SIM_RST = 1'b1; phase = '0; dcs = '0; din = 0; zerw = 0; bon = 0;
    ev_ready = 0; clr_ovf = 0;
    model_reset();
    @(posedge SIM_CLK); #2;
    check_all_zero("rst");
    @(posedge SIM_CLK); #2;
    SIM_RST = 1'b0;
    chk_en = 1;

    // Basic load on channel 1: dlo after edge DLY+2, then slot copy.
    apply(4'b0010, 4'b0010, 1, 1, 1, 0, 0);
    chk("basic_busy_e1", busy, 0);
    for (int e = 2; e <= 6; e++) begin
      apply(4'b0000, 4'b0010, 1, 1, 1, 0, 0);
      chk("basic_dlo", dlo, (e == 6) ? 1 : 0);
      if (e == 2) chk("basic_busy_e2", busy, 1);
    end
    chk("basic_dcr", dcr, 4'b0010);
    apply(4'b0000, 4'b0010, 1, 1, 1, 0, 0);
    chk("basic_dlo_e7", dlo, 0);
    apply(4'b0010, 4'b0010, 1, 1, 1, 0, 0);
    chk("basic_ddcr", ddcr, 4'b0010);
    chk("basic_dcr_clr", dcr, 4'b0000);
    chk("basic_ev_valid", ev_valid, 1);
    chk("basic_ev_data", ev_data, 3'b011);

    // Retrigger: a second rise retargets channel 3, single pulse.
    apply(4'b0010, 4'b0010, 0, 1, 1, 0, 0);
    apply(4'b0010, 4'b0010, 1, 1, 1, 0, 0);
    pulses = 0;
    apply(4'b1000, 4'b1000, 0, 1, 1, 0, 0); pulses += dlo;
    apply(4'b1000, 4'b1000, 1, 1, 1, 0, 0); pulses += dlo;
    for (int k = 0; k < 5; k++) begin
      apply(4'b0000, 4'b0000, 0, 1, 1, 0, 0);
      pulses += dlo;
    end
    chk("retrig_pulses", pulses, 1);
    chk("retrig_dcr", dcr, 4'b1000);
    for (int k = 0; k < 3; k++) apply(4'b0000, 4'b0000, 0, 1, 1, 1, 0);
    chk("drain_empty", ev_valid, 0);

    // Abort: dropping bon mid-count cancels without a pulse.
    apply(4'b0010, 4'b0010, 0, 1, 1, 0, 0);
    apply(4'b0010, 4'b0010, 1, 1, 1, 0, 0);
    apply(4'b0000, 4'b0000, 0, 1, 1, 0, 0);
    chk("abort_busy_run", busy, 1);
    apply(4'b0000, 4'b0000, 0, 1, 0, 0, 0);
    chk("abort_busy_off", busy, 0);
    pulses = 0;
    for (int k = 0; k < DLY + 2; k++) begin
      apply(4'b0000, 4'b0000, 0, 1, 1, 0, 0);
      pulses += dlo;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_dcr", dcr, 4'b1000);

    // zerw low: din ignored, no start.
    apply(4'b0010, 4'b0010, 0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) apply(4'b0010, 4'b0010, 1, 0, 1, 0, 0);
    apply(4'b0000, 4'b0000, 0, 1, 1, 0, 0);
    chk("zerw_busy", busy, 0);

    // Reset while counting: no pulse after release.
    apply(4'b0010, 4'b0010, 1, 1, 1, 0, 0);
    apply(4'b0000, 4'b0000, 0, 1, 1, 0, 0);
    mid_reset();
    pulses = 0;
    for (int k = 0; k < DLY + 3; k++) begin
      apply(4'b0000, 4'b0000, 0, 1, 1, 0, 0);
      pulses += dlo;
    end
    chk("rst_no_dlo", pulses, 0);

    // Randomized traffic with varying consumer readiness.
    for (int blk = 0; blk < 4; blk++) begin
      rdy_pct = (blk == 0) ? 10 : (blk == 1) ? 50 : (blk == 2) ? 90 : 30;
      for (int c = 0; c < 800; c++) begin
        sel = $urandom_range(0, 9);
        if (sel < 4) ph = '0;
        else if (sel < 9) ph = NCH'(1) << $urandom_range(0, NCH-1);
        else ph = NCH'($urandom);
        apply(ph, NCH'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 49) != 0), ($urandom_range(0, 99) < rdy_pct),
              ($urandom_range(0, 19) == 0));
      end
      mid_reset();
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
